// File: rtl/shift_encode_rr_arbiter.sv
// Eight-way round-robin arbiter built on a rotate/priority-encode unit.
// Optional forced release after HOLD_MAX cycles is enabled by defining SEA_TIMEOUT_EN.

module shift_encode_unit (
  input  logic [7:0] data_in,
  input  logic [1:0] mode,     // 00 pass, 01 shift left, 10 rotate left, 11 rotate right
  input  logic [2:0] shamt,
  output logic [2:0] pe_out,
  output logic       pe_valid
);

  logic [7:0] shifted;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    shifted = data_in;
    unique case (mode)
      2'b00: shifted = data_in;
      2'b01: for (int i = 0; i < 8; i++)
               shifted[i] = (3'(i) >= shamt) ? data_in[3'(i) - shamt] : 1'b0;
      2'b10: for (int i = 0; i < 8; i++) shifted[i] = data_in[3'(i) - shamt];
      2'b11: for (int i = 0; i < 8; i++) shifted[i] = data_in[3'(i) + shamt];
      default: shifted = data_in;
    endcase
  end

  // Highest set bit wins.
  always_comb begin
    pe_out = 3'd0;
    for (int i = 0; i < 8; i++)
      if (shifted[i]) pe_out = 3'(i);
  end

  assign pe_valid = |shifted;

endmodule

module shift_encode_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_q, timeout_d;

  logic [2:0] pe_out;
  logic       pe_valid;
  logic [2:0] winner;
  logic       expiry;
  logic       rel;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("HOLD_MAX must be in 1..255");
  end

  // Rotating left by -ptr puts requester ptr-1 at bit 7, making the last grantee lowest priority.
  shift_encode_unit u_seu (
    .data_in  (req),
    .mode     (2'b10),
    .shamt    (3'd0 - ptr_q),
    .pe_out   (pe_out),
    .pe_valid (pe_valid)
  );

  assign winner = pe_out + ptr_q;

`ifdef SEA_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_cnt_q, hold_cnt_d;

  // Expiry only counts when nothing else is releasing, so done or a dropped request suppress the pulse.
  assign expiry = (state_q == GRANT) && (hold_cnt_q == HOLD_LAST) && !done && req[gnt_idx_q];

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == IDLE && pe_valid)
      hold_cnt_d = 8'd0;
    else if (state_q == GRANT && !rel && hold_cnt_q != 8'hFF)
      hold_cnt_d = hold_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hold_cnt_q <= 8'd0;
    else        hold_cnt_q <= hold_cnt_d;
  end
`else
  assign expiry = 1'b0;
`endif

  assign rel = done || !req[gnt_idx_q] || expiry;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pe_valid) begin
          state_d     = GRANT;
          gnt_idx_d   = winner;
          gnt_d       = 8'b1 << winner;
          gnt_valid_d = 1'b1;
          ptr_d       = winner;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d     = IDLE;
          gnt_d       = 8'd0;
          gnt_valid_d = 1'b0;
          timeout_d   = expiry;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      gnt_q       <= 8'd0;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_shift_encode_rr_arbiter.sv
// Directed bench for shift_encode_rr_arbiter: per-cycle vector table plus timeout sequences.
// Timeout checks follow SEA_TIMEOUT_EN the same way the design does.

module tb_shift_encode_rr_arbiter;

  localparam int unsigned HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] exp_gnt;
    logic [2:0] exp_idx;
    logic       exp_valid;
    logic       exp_timeout;
  } vec_t;

  vec_t vecs[$];

  shift_encode_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [7:0] q, input logic d,
                              input logic [7:0] eg, input logic [2:0] ei,
                              input logic ev, input logic et);
    vec_t v;
    v.rst_n = r; v.req = q; v.done = d;
    v.exp_gnt = eg; v.exp_idx = ei; v.exp_valid = ev; v.exp_timeout = et;
    vecs.push_back(v);
  endfunction

  // Drive inputs, take one rising edge, settle 1 time unit past it.
  task automatic step(input logic r, input logic [7:0] q, input logic d);
    rst_n = r; req = q; done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = 8'h00; done = 1'b0;

    // Basic grant and rotation past the previous winner.
    add(0, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    add(1, 8'h90, 0, 8'h80, 3'd7, 1, 0);
    add(1, 8'h90, 1, 8'h00, 3'd7, 0, 0);
    add(1, 8'h90, 0, 8'h10, 3'd4, 1, 0);
    add(1, 8'h90, 1, 8'h00, 3'd4, 0, 0);
    add(1, 8'h00, 1, 8'h00, 3'd4, 0, 0);   // done while idle does nothing
    // Fairness with all eight requesting: 7,6,...,0,7 with a dead cycle between grants.
    add(0, 8'hFF, 0, 8'h00, 3'd0, 0, 0);
    for (int k = 7; k >= 0; k--) begin
      add(1, 8'hFF, 0, 8'(1 << k), 3'(k), 1, 0);
      add(1, 8'hFF, 1, 8'h00, 3'(k), 0, 0);
    end
    add(1, 8'hFF, 0, 8'h80, 3'd7, 1, 0);
    add(1, 8'hFF, 1, 8'h00, 3'd7, 0, 0);
    // Grantee drops its request; other request changes are ignored meanwhile.
    add(1, 8'h08, 0, 8'h08, 3'd3, 1, 0);
    add(1, 8'h28, 0, 8'h08, 3'd3, 1, 0);
    add(1, 8'h20, 0, 8'h00, 3'd3, 0, 0);
    // Mid-grant reset returns the pointer to 0.
    add(1, 8'h22, 0, 8'h02, 3'd1, 1, 0);
    add(0, 8'h22, 0, 8'h00, 3'd0, 0, 0);
    add(1, 8'h22, 0, 8'h20, 3'd5, 1, 0);
    add(1, 8'h00, 0, 8'h00, 3'd5, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].req, vecs[i].done);
      check($sformatf("row%0d gnt", i),       32'(gnt),       32'(vecs[i].exp_gnt));
      check($sformatf("row%0d gnt_idx", i),   32'(gnt_idx),   32'(vecs[i].exp_idx));
      check($sformatf("row%0d gnt_valid", i), 32'(gnt_valid), 32'(vecs[i].exp_valid));
      check($sformatf("row%0d timeout", i),   32'(timeout),   32'(vecs[i].exp_timeout));
    end

    // Long hold on requester 0.
    step(0, 8'h00, 0);
    step(1, 8'h01, 0);
    check("hold grant idx", 32'(gnt_idx), 32'd0);
`ifdef SEA_TIMEOUT_EN
    for (int c = 1; c < int'(HOLD); c++) begin
      check($sformatf("hold valid c%0d", c), 32'(gnt_valid), 32'd1);
      check($sformatf("hold no timeout c%0d", c), 32'(timeout), 32'd0);
      step(1, 8'h01, 0);
    end
    check("hold valid last", 32'(gnt_valid), 32'd1);
    step(1, 8'h01, 0);
    check("expiry drops valid", 32'(gnt_valid), 32'd0);
    check("expiry timeout pulse", 32'(timeout), 32'd1);
    step(1, 8'h01, 0);
    check("regrant after expiry valid", 32'(gnt_valid), 32'd1);
    check("regrant after expiry idx", 32'(gnt_idx), 32'd0);
    check("timeout one cycle", 32'(timeout), 32'd0);
    for (int c = 1; c < int'(HOLD); c++) step(1, 8'h01, 0);
    check("pre-coincide valid", 32'(gnt_valid), 32'd1);
`else
    for (int c = 0; c < 20; c++) begin
      step(1, 8'h01, 0);
      check($sformatf("held valid c%0d", c), 32'(gnt_valid), 32'd1);
      check($sformatf("held no timeout c%0d", c), 32'(timeout), 32'd0);
    end
`endif
    // done coinciding with expiry (or with a plain hold): done wins, no timeout.
    step(1, 8'h01, 1);
    check("coincide valid", 32'(gnt_valid), 32'd0);
    check("coincide timeout", 32'(timeout), 32'd0);
    step(1, 8'h00, 0);
    check("idle after coincide", 32'(gnt_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_encode_rr_arbiter.md
# shift_encode_rr_arbiter

Round-robin arbiter for eight requesters, built around one `shift_encode_unit` instance. The unit runs in rotate-left mode: the rotate shifts the request vector so that the most recently granted requester becomes lowest priority, and the priority encoder picks the winner. A registered FSM holds each grant until the requester releases it, drops its request, or (optionally) times out. The block sits between requesting agents and a shared resource that accepts one owner at a time.

## Interface
- `HOLD_MAX`, default 16: maximum grant length in cycles when the timeout is compiled in. Legal range 1..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  8  request vector; bit i is requester i.
- `done`  in  1  grantee releases the grant; ignored unless `gnt_valid`=1.
- `gnt`  out  8  one-hot grant; registered.
- `gnt_idx`  out  3  index of the current grantee; registered.
- `gnt_valid`  out  1  a grant is active; registered.
- `timeout`  out  1  one-cycle pulse when a grant is force-released; registered.

## Operation
- Internal `ptr[2:0]` holds the last granted index. Reset value is 0.
- Arbitration datapath feeding the `shift_encode_unit` instance:
  - `in`=`req`, `mode`=2'b10 (rotate left), `shamt`=(8−`ptr`) mod 8, i.e. 3-bit −`ptr`.
  - The rotation maps requester `ptr`−1 to bit 7 (highest priority) and requester `ptr` to bit 0 (lowest).
  - Winner index = (`pe_out` + `ptr`) mod 8, using natural 3-bit wrap.
  - A request exists when `pe_valid`=1.
- Resulting priority after granting g: g−1, g−2, …, 0, 7, …, g.
- After reset, `ptr`=0, so requester 7 has the highest priority.
- FSM states:
  - IDLE:
    - If `pe_valid`=1: go to GRANT. Load `gnt_idx`=winner, set `gnt`=1<<winner, `gnt_valid`=1, `ptr`=winner, clear the hold counter.
    - Otherwise stay in IDLE.
  - GRANT:
    - Release condition: `done`=1, OR `req[gnt_idx]`=0, OR timeout expiry.
    - On release: go to IDLE and clear `gnt`/`gnt_valid`.
    - Otherwise stay in GRANT and increment the hold counter (8-bit, saturating).
- Timeout expiry (only with the macro): hold counter = `HOLD_MAX`−1 while in GRANT with no other release. `timeout` pulses in the same cycle that the grant drops.
  - If `done` and expiry coincide, `done` wins and `timeout` stays 0.
- While in GRANT, changes to `req` on bits other than the grantee's are ignored.
- A release always passes through one IDLE cycle before the next grant (dead cycle).
- `gnt_idx` holds its last value while `gnt_valid`=0.

## Timing
- Reset values (`rst_n`=0 at an edge):
  - `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0, `ptr`=0, state IDLE, hold counter 0.
  - Reset is applied even mid-grant: outputs clear at that edge.
- Grant latency: request visible in IDLE at edge N → `gnt_valid`=1 after edge N.
- Release latency: release condition sampled at edge M → `gnt_valid`=0 after edge M.
  - Next grant follows earliest after edge M+1.
- Maximum grant duration with the timeout: exactly `HOLD_MAX` cycles of `gnt_valid`=1.
- Fairness: with all eight requesting continuously, every requester is granted once per 8 grants.
- `done` asserted with `gnt_valid`=0 has no effect.

## Configuration
- Macro `SEA_TIMEOUT_EN`.
- Defined: the hold counter and forced release are active, and `timeout` pulses as described in Operation.
- Undefined:
  - The counter logic is removed and `timeout` is tied to 0.
  - Grants are held until `done` or the grantee's request drops.
  - `HOLD_MAX` is unused.

## Test plan
- Reset, then `req`=8'h90 → `gnt_idx`=7 one cycle later. Pulse `done` → one idle cycle, then `gnt_idx`=4 (`gnt`=8'h10).
- `req`=8'hFF held, `done` pulsed on each grant cycle → `gnt_idx` sequence 7,6,5,4,3,2,1,0,7, with one idle cycle between grants.
- With `SEA_TIMEOUT_EN`, `HOLD_MAX`=4, `req`=8'h01, `done`=0 → `gnt_valid` high for exactly 4 cycles, `timeout` pulses in the drop cycle, one idle cycle, then `gnt_idx`=0 again. Without the macro, the grant is held indefinitely.
- Grant at index 3 (`req`=8'h08); drop `req[3]` → `gnt_valid`=0 next edge, `timeout`=0.
- Mid-grant `rst_n`=0 for one edge with `req`=8'h22 still asserted → all outputs are 0 after that edge. With `ptr` back at 0, the next grant is `gnt_idx`=5.
- `done` and timeout expiry in the same cycle → grant released, `timeout` stays 0.
